// File: rtl/spi_flash_id_responder.sv
// SPI mode-0 slave answering the JEDEC Read ID (0x9F) and Read Mfr/Dev ID (0x90) commands.
// Ports: clk/rst, spi_sck_i/spi_cs_n_i/spi_mosi_i (async), spi_miso_o/spi_miso_oe, cmd_valid/cmd_byte, busy.
module spi_flash_id_responder #(
  parameter logic [7:0] ID_MFR    = 8'hEF,
  parameter logic [7:0] ID_TYPE   = 8'h40,
  parameter logic [7:0] ID_CAP    = 8'h18,
  parameter logic [7:0] ID_DEV    = 8'h17,
  parameter logic       IDLE_MISO = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       spi_sck_i,
  input  logic       spi_cs_n_i,
  input  logic       spi_mosi_i,
  output logic       spi_miso_o,
  output logic       spi_miso_oe,
  output logic       cmd_valid,
  output logic [7:0] cmd_byte,
  output logic       busy
);

  typedef enum logic [2:0] {
    S_IDLE, S_CMD, S_ID9F, S_ADDR, S_ID90, S_IGNORE
  } state_t;

  logic [1:0] sck_sync_q, cs_sync_q, mosi_sync_q;
  logic       sck_hist_q;

  state_t     state_q, state_d;
  logic [2:0] bit_cnt_q, bit_cnt_d;
  logic [2:0] byte_cnt_q, byte_cnt_d;
  logic [7:0] rx_sr_q, rx_sr_d;
  logic [7:0] tx_sr_q, tx_sr_d;
  logic [1:0] idx_q, idx_d;
  logic       alt_q, alt_d;
  logic       miso_q, miso_d;
  logic       cmd_valid_q, cmd_valid_d;
  logic [7:0] cmd_byte_q, cmd_byte_d;

  logic       sck_s, cs_act, mosi_s;
  logic       sck_rise, sck_fall;
  logic [7:0] rx_new;
  logic [7:0] nxt_byte;

  always_ff @(posedge clk) begin
    if (rst) begin
      sck_sync_q  <= 2'b00;
      cs_sync_q   <= 2'b11;
      mosi_sync_q <= 2'b00;
      sck_hist_q  <= 1'b0;
    end else begin
      sck_sync_q  <= {sck_sync_q[0], spi_sck_i};
      cs_sync_q   <= {cs_sync_q[0], spi_cs_n_i};
      mosi_sync_q <= {mosi_sync_q[0], spi_mosi_i};
      sck_hist_q  <= sck_sync_q[1];
    end
  end

  assign sck_s    = sck_sync_q[1];
  assign cs_act   = ~cs_sync_q[1];
  assign mosi_s   = mosi_sync_q[1];
  assign sck_rise = sck_s & ~sck_hist_q;
  assign sck_fall = ~sck_s & sck_hist_q;
  assign rx_new   = {rx_sr_q[6:0], mosi_s};

  // Next 0x9F response byte, selected by the rotating index.
  always_comb begin
    nxt_byte = ID_MFR;
    unique case (idx_q)
      2'd1:    nxt_byte = ID_TYPE;
      2'd2:    nxt_byte = ID_CAP;
      default: nxt_byte = ID_MFR;
    endcase
  end

  always_comb begin
    state_d     = state_q;
    bit_cnt_d   = bit_cnt_q;
    byte_cnt_d  = byte_cnt_q;
    rx_sr_d     = rx_sr_q;
    tx_sr_d     = tx_sr_q;
    idx_d       = idx_q;
    alt_d       = alt_q;
    miso_d      = miso_q;
    cmd_valid_d = 1'b0;
    cmd_byte_d  = cmd_byte_q;

    if (state_q == S_IDLE || !cs_act) begin
      // CS release beats any simultaneous SCK edge.
      miso_d     = IDLE_MISO;
      bit_cnt_d  = 3'd0;
      byte_cnt_d = 3'd0;
      state_d    = cs_act ? S_CMD : S_IDLE;
    end else if (sck_rise) begin
      rx_sr_d   = rx_new;
      bit_cnt_d = bit_cnt_q + 3'd1;
      if (bit_cnt_q == 3'd7) begin
        if (byte_cnt_q != 3'd7) byte_cnt_d = byte_cnt_q + 3'd1;
        unique case (state_q)
          S_CMD: begin
            cmd_byte_d  = rx_new;
            cmd_valid_d = 1'b1;
            if (rx_new == 8'h9F) begin
              tx_sr_d = ID_MFR;
              miso_d  = ID_MFR[7];
              idx_d   = 2'd1;
              state_d = S_ID9F;
            end else if (rx_new == 8'h90) begin
              state_d = S_ADDR;
            end else begin
              state_d = S_IGNORE;
            end
          end
          S_ID9F: begin
            tx_sr_d = nxt_byte;
            miso_d  = nxt_byte[7];
            idx_d   = (idx_q == 2'd2) ? 2'd0 : idx_q + 2'd1;
          end
          S_ADDR: begin
            // Command was byte 0, so the last address byte ends at count 3.
            if (byte_cnt_q == 3'd3) begin
              tx_sr_d = rx_new[0] ? ID_DEV : ID_MFR;
              miso_d  = rx_new[0] ? ID_DEV[7] : ID_MFR[7];
              alt_d   = ~rx_new[0];
              state_d = S_ID90;
            end
          end
          S_ID90: begin
            tx_sr_d = alt_q ? ID_DEV : ID_MFR;
            miso_d  = alt_q ? ID_DEV[7] : ID_MFR[7];
            alt_d   = ~alt_q;
          end
          default: ;
        endcase
      end
    end else if (sck_fall) begin
      // bit_cnt==0 means the byte was just loaded with its MSB already out.
      if ((state_q == S_ID9F || state_q == S_ID90) && bit_cnt_q != 3'd0) begin
        tx_sr_d = {tx_sr_q[6:0], 1'b0};
        miso_d  = tx_sr_q[6];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      bit_cnt_q   <= 3'd0;
      byte_cnt_q  <= 3'd0;
      rx_sr_q     <= 8'h00;
      tx_sr_q     <= 8'h00;
      idx_q       <= 2'd0;
      alt_q       <= 1'b0;
      miso_q      <= IDLE_MISO;
      cmd_valid_q <= 1'b0;
      cmd_byte_q  <= 8'h00;
    end else begin
      state_q     <= state_d;
      bit_cnt_q   <= bit_cnt_d;
      byte_cnt_q  <= byte_cnt_d;
      rx_sr_q     <= rx_sr_d;
      tx_sr_q     <= tx_sr_d;
      idx_q       <= idx_d;
      alt_q       <= alt_d;
      miso_q      <= miso_d;
      cmd_valid_q <= cmd_valid_d;
      cmd_byte_q  <= cmd_byte_d;
    end
  end

  assign spi_miso_o  = miso_q;
  assign spi_miso_oe = (state_q != S_IDLE);
  assign cmd_valid   = cmd_valid_q;
  assign cmd_byte    = cmd_byte_q;
  assign busy        = cs_act;

endmodule

// File: tb/tb_spi_flash_id_responder.sv
// Directed bench for spi_flash_id_responder: drives SPI mode-0 frames
// and checks MISO bytes, cmd_valid/cmd_byte, oe/busy, abort and reset.
module tb_spi_flash_id_responder;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       sck = 1'b0;
  logic       cs_n = 1'b1;
  logic       mosi = 1'b0;
  logic       miso, oe, cmd_valid, busy;
  logic [7:0] cmd_byte;

  int errors = 0;
  int checks = 0;
  int cv_cnt = 0;
  int cv_base;
  logic [7:0] rx;

  spi_flash_id_responder dut (
    .clk(clk),
    .rst(rst),
    .spi_sck_i(sck),
    .spi_cs_n_i(cs_n),
    .spi_mosi_i(mosi),
    .spi_miso_o(miso),
    .spi_miso_oe(oe),
    .cmd_valid(cmd_valid),
    .cmd_byte(cmd_byte),
    .busy(busy)
  );

  always #5 clk = ~clk;

  always @(negedge clk)
    if (cmd_valid === 1'b1) cv_cnt++;

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic half();
    repeat (6) @(negedge clk);
  endtask

  // Shift n bits MSB-first; MISO sampled on each master rise.
  task automatic xfer(input logic [7:0] tx, input int n,
                      output logic [7:0] rxo);
    rxo = 8'h00;
    for (int i = 0; i < n; i++) begin
      mosi = tx[7-i];
      half();
      rxo = {rxo[6:0], miso};
      sck = 1'b1;
      half();
      sck = 1'b0;
    end
  endtask

  task automatic cs_low();
    @(negedge clk);
    cs_n = 1'b0;
    half();
  endtask

  task automatic cs_high();
    half();
    cs_n = 1'b1;
    repeat (8) @(negedge clk);
  endtask

  initial begin
    repeat (4) @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_miso", miso, 1);
    check("rst_oe", oe, 0);
    check("rst_cv", cmd_valid, 0);
    check("rst_cmd", cmd_byte, 8'h00);
    check("rst_busy", busy, 0);

    // Read ID 0x9F, three response bytes
    cv_base = cv_cnt;
    cs_low();
    check("f1_busy", busy, 1);
    check("f1_oe", oe, 1);
    xfer(8'h9F, 8, rx);
    xfer(8'hFF, 8, rx); check("f1_b0", rx, 8'hEF);
    xfer(8'hFF, 8, rx); check("f1_b1", rx, 8'h40);
    xfer(8'hFF, 8, rx); check("f1_b2", rx, 8'h18);
    check("f1_oe_end", oe, 1);
    cs_high();
    check("f1_cv", cv_cnt - cv_base, 1);
    check("f1_cmd", cmd_byte, 8'h9F);
    check("f1_oe_off", oe, 0);
    check("f1_busy_off", busy, 0);
    check("f1_miso_idle", miso, 1);

    // 0x9F wrap over six bytes
    cs_low();
    xfer(8'h9F, 8, rx);
    xfer(8'hFF, 8, rx); check("f2_b0", rx, 8'hEF);
    xfer(8'hFF, 8, rx); check("f2_b1", rx, 8'h40);
    xfer(8'hFF, 8, rx); check("f2_b2", rx, 8'h18);
    xfer(8'hFF, 8, rx); check("f2_b3", rx, 8'hEF);
    xfer(8'hFF, 8, rx); check("f2_b4", rx, 8'h40);
    xfer(8'hFF, 8, rx); check("f2_b5", rx, 8'h18);
    cs_high();

    // 0x90 with odd address: DEV first
    cs_low();
    xfer(8'h90, 8, rx);
    xfer(8'h00, 8, rx); check("f3_a0", rx, 8'hFF);
    xfer(8'h00, 8, rx); check("f3_a1", rx, 8'hFF);
    xfer(8'h01, 8, rx); check("f3_a2", rx, 8'hFF);
    xfer(8'hFF, 8, rx); check("f3_b0", rx, 8'h17);
    xfer(8'hFF, 8, rx); check("f3_b1", rx, 8'hEF);
    xfer(8'hFF, 8, rx); check("f3_b2", rx, 8'h17);
    xfer(8'hFF, 8, rx); check("f3_b3", rx, 8'hEF);
    cs_high();
    check("f3_cmd", cmd_byte, 8'h90);

    // 0x90 with even address: MFR first
    cs_low();
    xfer(8'h90, 8, rx);
    xfer(8'h00, 8, rx);
    xfer(8'h00, 8, rx);
    xfer(8'h02, 8, rx);
    xfer(8'hFF, 8, rx); check("f3e_b0", rx, 8'hEF);
    xfer(8'hFF, 8, rx); check("f3e_b1", rx, 8'h17);
    cs_high();

    // Unknown command 0x03
    cv_base = cv_cnt;
    cs_low();
    xfer(8'h03, 8, rx);
    xfer(8'hFF, 8, rx); check("f4_b0", rx, 8'hFF);
    xfer(8'hFF, 8, rx); check("f4_b1", rx, 8'hFF);
    check("f4_oe", oe, 1);
    cs_high();
    check("f4_cv", cv_cnt - cv_base, 1);
    check("f4_cmd", cmd_byte, 8'h03);

    // Abort after 5 bits: no cmd_valid, cmd_byte held
    cv_base = cv_cnt;
    cs_low();
    xfer(8'h9F, 5, rx);
    cs_high();
    check("f5_cv", cv_cnt - cv_base, 0);
    check("f5_cmd", cmd_byte, 8'h03);
    check("f5_oe", oe, 0);

    // Full 0x9F frame after the abort
    cv_base = cv_cnt;
    cs_low();
    xfer(8'h9F, 8, rx);
    xfer(8'hFF, 8, rx); check("f6_b0", rx, 8'hEF);
    xfer(8'hFF, 8, rx); check("f6_b1", rx, 8'h40);
    xfer(8'hFF, 8, rx); check("f6_b2", rx, 8'h18);
    cs_high();
    check("f6_cv", cv_cnt - cv_base, 1);
    check("f6_cmd", cmd_byte, 8'h9F);

    // Reset after 12 ID bits
    cs_low();
    xfer(8'h9F, 8, rx);
    xfer(8'hFF, 8, rx); check("f7_b0", rx, 8'hEF);
    xfer(8'hFF, 4, rx); check("f7_nib", rx, 8'h04);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    check("f7_miso", miso, 1);
    check("f7_oe", oe, 0);
    check("f7_busy", busy, 0);
    check("f7_cmd", cmd_byte, 8'h00);
    @(negedge clk);
    rst = 1'b0;
    cs_n = 1'b1;
    repeat (8) @(negedge clk);

    // New frame after reset
    cs_low();
    xfer(8'h9F, 8, rx);
    xfer(8'hFF, 8, rx); check("f8_b0", rx, 8'hEF);
    xfer(8'hFF, 8, rx); check("f8_b1", rx, 8'h40);
    xfer(8'hFF, 8, rx); check("f8_b2", rx, 8'h18);
    cs_high();
    check("f8_cmd", cmd_byte, 8'h9F);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
